bnn_xnor_popcount_acc: RTL

//  Binary-neuron compute stage directly downstream of the dmem address generator.

---
 rtl/bnn_xnor_popcount_acc.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bnn_xnor_popcount_acc.sv
// bnn_xnor_popcount_acc
// Binary-neuron compute stage. Each accepted beat XNORs an activation word with
// its weight word and popcounts the result. BEATS popcounts are accumulated per
// neuron. The sum is compared against the threshold captured on beat 0, and the
// resulting neuron bits are packed OUT_W at a time into out_word_o.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous reset, active-low
//   clear_i         synchronous flush of all state except out_word_o
//   in_valid_i      in_data_i / in_weight_i / thresh_i valid this cycle
//   in_data_i       activation word
//   in_weight_i     weight word aligned with in_data_i
//   thresh_i        firing threshold, sampled on beat 0 of each neuron
//   neuron_bit_o    1 when the accumulated sum >= the latched threshold
//   neuron_valid_o  1-cycle pulse qualifying neuron_bit_o
//   out_word_o      packed neuron bits, first neuron in bit 0
//   out_valid_o     1-cycle pulse when out_word_o has just been completed
//   busy_o          a neuron is partially accumulated or the pipe holds a beat
module bnn_xnor_popcount_acc #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 48,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [DATA_W-1:0] in_weight_i,
    input  logic [ACC_W-1:0]  thresh_i,
    output logic              neuron_bit_o,
    output logic              neuron_valid_o,
    output logic [OUT_W-1:0]  out_word_o,
    output logic              out_valid_o,
    output logic              busy_o
);

    localparam int PC_W  = $clog2(DATA_W + 1);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    // Number of set bits in a data-width word.
    function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {{(PC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             pv_q, pv_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             neuron_bit_q, neuron_bit_d;
    logic             neuron_valid_q, neuron_valid_d;
    logic [OUT_W-1:0] word_sr_q, word_sr_d;
    logic [OUT_W-1:0] out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] sum_s;
    logic [OUT_W-1:0] word_shift_s;

    // The first beat of a neuron restarts the sum rather than adding to acc_q,
    // so a new neuron can follow the previous one's last beat without a bubble.
    assign sum_s        = (first_q ? {ACC_W{1'b0}} : acc_q) + {{(ACC_W-PC_W){1'b0}}, pc_q};
    assign word_shift_s = {neuron_bit_q, word_sr_q[OUT_W-1:1]};

    // Next-state logic for the popcount pipe, accumulator and packer.
    always_comb begin
        beat_cnt_d     = beat_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        acc_d          = acc_q;
        thr_d          = thr_q;
        pc_d           = pc_q;
        pv_d           = 1'b0;
        first_d        = first_q;
        last_d         = last_q;
        neuron_bit_d   = neuron_bit_q;
        neuron_valid_d = 1'b0;
        word_sr_d      = word_sr_q;
        out_word_d     = out_word_q;
        out_valid_d    = 1'b0;

        if (clear_i) begin
            // Flush everything except the last completed word; a coincident beat is dropped.
            beat_cnt_d   = '0;
            bit_cnt_d    = '0;
            acc_d        = '0;
            thr_d        = '0;
            pc_d         = '0;
            first_d      = 1'b0;
            last_d       = 1'b0;
            neuron_bit_d = 1'b0;
            word_sr_d    = '0;
        end else begin
            pv_d = in_valid_i;
            if (in_valid_i) begin
                pc_d    = popcount(~(in_data_i ^ in_weight_i));
                first_d = (beat_cnt_q == CNT_W'(0));
                last_d  = (beat_cnt_q == CNT_W'(BEATS-1));
                if (beat_cnt_q == CNT_W'(BEATS-1)) begin
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (beat_cnt_q == CNT_W'(0)) begin
                    thr_d = thresh_i;
                end else begin
                    thr_d = thr_q;
                end
            end else begin
                beat_cnt_d = beat_cnt_q;
            end

            if (pv_q) begin
                if (last_q) begin
                    neuron_bit_d   = (sum_s >= thr_q);
                    neuron_valid_d = 1'b1;
                    acc_d          = '0;
                end else begin
                    acc_d = sum_s;
                end
            end else begin
                acc_d = acc_q;
            end

            if (neuron_valid_q) begin
                word_sr_d = word_shift_s;
                if (bit_cnt_q == BIT_W'(OUT_W-1)) begin
                    out_word_d  = word_shift_s;
                    out_valid_d = 1'b1;
                    bit_cnt_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end else begin
                word_sr_d = word_sr_q;
            end
        end

        busy_d = (beat_cnt_d != CNT_W'(0)) | pv_d;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            acc_q          <= '0;
            thr_q          <= '0;
            pc_q           <= '0;
            pv_q           <= 1'b0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            neuron_bit_q   <= 1'b0;
            neuron_valid_q <= 1'b0;
            word_sr_q      <= '0;
            out_word_q     <= '0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            beat_cnt_q     <= beat_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            acc_q          <= acc_d;
            thr_q          <= thr_d;
            pc_q           <= pc_d;
            pv_q           <= pv_d;
            first_q        <= first_d;
            last_q         <= last_d;
            neuron_bit_q   <= neuron_bit_d;
            neuron_valid_q <= neuron_valid_d;
            word_sr_q      <= word_sr_d;
            out_word_q     <= out_word_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign neuron_bit_o   = neuron_bit_q;
    assign neuron_valid_o = neuron_valid_q;
    assign out_word_o     = out_word_q;
    assign out_valid_o    = out_valid_q;
    assign busy_o         = busy_q;

endmodule
